// File: rtl/studio2_pkg.sv
// Shared constants and types for the Studio II keypad responder.
package studio2_pkg;

    localparam int          NUM_KEYS     = 10;
    localparam logic [3:0]  KEY_NONE     = 4'hF;
    localparam logic [2:0]  KEYSEL_N_DEF = 3'd2;

    // Keypad 1: main-keyboard digits 0-9 (non-extended set 2 codes)
    localparam logic [7:0] PAD1_CODES [NUM_KEYS] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
    };

    // Keypad 2: numeric-keypad digits 0-9 (non-extended set 2 codes)
    localparam logic [7:0] PAD2_CODES [NUM_KEYS] = '{
        8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D
    };

    // Decoded key: pad 0 = keypad 1, pad 1 = keypad 2
    typedef struct packed {
        logic       valid;
        logic       pad;
        logic [3:0] digit;
    } key_t;

    // Selects matrix bit idx; indices 10-15 select nothing and return 0
    function automatic logic key_sel(input logic [9:0] m, input logic [3:0] idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            hit = hit | (m[i] & (idx == 4'(i)));
        end
        return hit;
    endfunction

endpackage

// File: rtl/studio2_scancode_dec.sv
// Combinational PS/2 scancode to keypad/digit decoder.
module studio2_scancode_dec
    import studio2_pkg::*;
(
    input  logic [7:0] code_i,
    input  logic       ext_i,
    output key_t       key_o
);

    // Match the code against both keypad tables; extended codes never match
    always_comb begin
        key_o = '{valid: 1'b0, pad: 1'b0, digit: KEY_NONE};
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (!ext_i && (code_i == PAD1_CODES[i])) begin
                key_o = '{valid: 1'b1, pad: 1'b0, digit: 4'(i)};
            end else if (!ext_i && (code_i == PAD2_CODES[i])) begin
                key_o = '{valid: 1'b1, pad: 1'b1, digit: 4'(i)};
            end else begin
                key_o = key_o;
            end
        end
    end

endmodule

// File: rtl/studio2_keypad.sv
// Studio II keypad responder: PS/2 key matrix, key-select latch and EF3/EF4.
module studio2_keypad
    import studio2_pkg::*;
#(
    parameter int         STRETCH  = 1,
    parameter logic [2:0] KEYSEL_N = KEYSEL_N_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        io_out,
    input  logic [2:0]  io_n,
    input  logic [7:0]  io_dout,
    output logic        ef3_n,
    output logic        ef4_n,
    output logic [3:0]  key_latch,
    output logic [9:0]  keys1,
    output logic [9:0]  keys2
);

    // Index [0] is keypad 1, [1] is keypad 2
    logic [1:0][9:0] keys_q, keys_d;
    logic [1:0][9:0] pend_q, pend_d;
    logic [1:0][9:0] seen_q, seen_d;
    logic [1:0][9:0] scanned_s;
    logic [3:0]      latch_q, latch_d;
    logic            tog_q;
    logic            io_out_q;
    logic            ef3_q, ef4_q;
    logic            event_s;
    logic            wr_s;
    key_t            dkey_s;
    logic            unused_s;

    assign unused_s = ^io_dout[7:4];

    studio2_scancode_dec u_dec (
        .code_i (ps2_key[7:0]),
        .ext_i  (ps2_key[8]),
        .key_o  (dkey_s)
    );

    // Next-state for matrix, pending/seen flags and latch; latch-write
    // pending clears use the old latch and are applied before the PS/2 event
    always_comb begin
        event_s = (ps2_key[10] != tog_q);
        wr_s    = io_out & ~io_out_q & (io_n == KEYSEL_N);
        keys_d  = keys_q;
        pend_d  = pend_q;
        latch_d = wr_s ? io_dout[3:0] : latch_q;

        for (int p = 0; p < 2; p++) begin
            for (int d = 0; d < NUM_KEYS; d++) begin
                scanned_s[p][d] = seen_q[p][d] | (keys_q[p][d] & (latch_q == 4'(d)));
            end
        end
        seen_d = scanned_s;

        if (wr_s && (latch_q < 4'd10)) begin
            for (int p = 0; p < 2; p++) begin
                if (pend_q[p][latch_q]) begin
                    keys_d[p][latch_q] = 1'b0;
                    pend_d[p][latch_q] = 1'b0;
                end else begin
                    keys_d[p][latch_q] = keys_d[p][latch_q];
                end
            end
        end else begin
            keys_d = keys_d;
        end

        if (event_s && dkey_s.valid) begin
            if (ps2_key[9]) begin
                keys_d[dkey_s.pad][dkey_s.digit] = 1'b1;
                pend_d[dkey_s.pad][dkey_s.digit] = 1'b0;
                seen_d[dkey_s.pad][dkey_s.digit] = 1'b0;
            end else if ((STRETCH == 0) || scanned_s[dkey_s.pad][dkey_s.digit]
                         || !keys_d[dkey_s.pad][dkey_s.digit]) begin
                keys_d[dkey_s.pad][dkey_s.digit] = 1'b0;
                pend_d[dkey_s.pad][dkey_s.digit] = 1'b0;
            end else begin
                pend_d[dkey_s.pad][dkey_s.digit] = 1'b1;
            end
        end else begin
            pend_d = pend_d;
        end
    end

    // State registers; the toggle and strobe history reload from the inputs
    // on reset so a level held across reset produces no event or write
    always_ff @(posedge clk) begin
        if (reset) begin
            keys_q   <= '0;
            pend_q   <= '0;
            seen_q   <= '0;
            latch_q  <= 4'd0;
            tog_q    <= ps2_key[10];
            io_out_q <= io_out;
            ef3_q    <= 1'b1;
            ef4_q    <= 1'b1;
        end else begin
            keys_q   <= keys_d;
            pend_q   <= pend_d;
            seen_q   <= seen_d;
            latch_q  <= latch_d;
            tog_q    <= ps2_key[10];
            io_out_q <= io_out;
            ef3_q    <= ~key_sel(keys_q[0], latch_q);
            ef4_q    <= ~key_sel(keys_q[1], latch_q);
        end
    end

    assign ef3_n     = ef3_q;
    assign ef4_n     = ef4_q;
    assign key_latch = latch_q;
    assign keys1     = keys_q[0];
    assign keys2     = keys_q[1];

endmodule
